// File: rtl/bus_pkg.sv
// Shared widths, FSM encoding and request payload for the bus master port.
package bus_pkg;

  localparam int unsigned ADDR_WIDTH             = 16;
  localparam int unsigned DATA_WIDTH             = 32;
  localparam int unsigned SPLIT_DELAY_CYCLES     = 1;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SPLIT = 2'd3
  } master_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  we;
    logic                  split;
  } bus_req_t;

  // Split transfers only make sense for reads.
  function automatic logic split_request(input bus_req_t req);
    return req.split & ~req.we;
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Counts unanswered bus-wait cycles; o_expired_c flags the cycle that reaches LIMIT.
module bus_timeout_cnt #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at LIMIT so a held enable cannot wrap around.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != CNT_W'(LIMIT))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired_c = i_enable && (r_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/bus_master_port.sv
// Single-outstanding bus master: captures a user request, issues it for one
// cycle, then waits (optionally through a split phase) for completion or timeout.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic                  req_we_i,
  input  logic                  req_split_i,
  output logic                  valid_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  we_o,
  output logic                  split_start_o,
  input  logic                  ready_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  err_i,
  input  logic                  split_busy_i,
  input  logic                  split_ready_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic                  rsp_split_o
);

  master_state_e r_state;
  master_state_e w_state_nxt;
  bus_req_t      r_req;
  bus_req_t      w_req_in;

  logic                  r_req_ready;
  logic                  r_valid;
  logic                  r_split_start;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_rsp_timeout;
  logic                  r_rsp_split;

  logic w_busy;
  logic w_done;
  logic w_expired;
  logic w_accept;

  assign w_req_in = '{addr: req_addr_i, wdata: req_wdata_i, we: req_we_i, split: req_split_i};
  assign w_accept = (r_state == ST_IDLE) && req_valid_i;
  assign w_busy   = (r_state == ST_WAIT) || (r_state == ST_SPLIT);
  assign w_done   = w_busy && ready_i;

  bus_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_clear     (!w_busy),
    .i_enable    (w_busy && !ready_i),
    .o_expired_c (w_expired)
  );

  // Next-state logic; a completion always beats an expiring timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid_i) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (w_done || w_expired) w_state_nxt = ST_IDLE;
        else if (split_busy_i)   w_state_nxt = ST_SPLIT;
      end
      ST_SPLIT: if (w_done || w_expired) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_req         <= '0;
      r_req_ready   <= 1'b1;
      r_valid       <= 1'b0;
      r_split_start <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_split   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_req_ready   <= (w_state_nxt == ST_IDLE);
      r_valid       <= (w_state_nxt == ST_ISSUE);
      r_rsp_valid   <= w_done || w_expired;
      r_split_start <= w_accept && split_request(w_req_in);
      if (w_accept) begin
        r_req <= w_req_in;
      end
      // Response fields hold between completions.
      if (w_done) begin
        r_rsp_rdata   <= r_req.we ? '0 : rdata_i;
        r_rsp_err     <= err_i;
        r_rsp_timeout <= 1'b0;
        r_rsp_split   <= !r_req.we && ((r_state == ST_SPLIT) || split_ready_i);
      end else if (w_expired) begin
        r_rsp_rdata   <= '0;
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
        r_rsp_split   <= 1'b0;
      end
    end
  end

  assign req_ready_o   = r_req_ready;
  assign valid_o       = r_valid;
  assign addr_o        = r_req.addr;
  assign wdata_o       = r_req.wdata;
  assign we_o          = r_req.we;
  assign split_start_o = r_split_start;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_err_o     = r_rsp_err;
  assign rsp_timeout_o = r_rsp_timeout;
  assign rsp_split_o   = r_rsp_split;

endmodule
